// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port integer register file with load scoreboard
//
// Purpose: RD_PORTS combinational read ports, write port A (in-order pipeline
// writeback) and write port B (late load return). A per-register busy bit
// tracks outstanding loads so decode can stall on RAW hazards. With FWD=1,
// same-cycle write data is bypassed to the read ports.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rd_addr, rd_use     packed read addresses, per-port operand-consumed flags
//   rd_data, rd_busy    packed read data, per-port busy of addressed register
//   stall               any consumed operand has a load outstanding
//   wa_en/addr/data     pipeline writeback port
//   wb_en/addr/data     load-return port (accepted only while busy)
//   claim_en/addr       load issued, mark destination busy
//   flush               clear all busy bits
//   busy_vec            registered busy bits
//   drop_cnt            saturating count of dropped port-B writes
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int REG_NUM  = 32,
  parameter int RD_PORTS = 2,
  parameter int FWD      = 1,
  parameter int AW       = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RD_PORTS*AW-1:0]     rd_addr,
  input  logic [RD_PORTS-1:0]        rd_use,
  output logic [RD_PORTS*DATA_W-1:0] rd_data,
  output logic [RD_PORTS-1:0]        rd_busy,
  output logic                       stall,
  input  logic                       wa_en,
  input  logic [AW-1:0]              wa_addr,
  input  logic [DATA_W-1:0]          wa_data,
  input  logic                       wb_en,
  input  logic [AW-1:0]              wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       claim_en,
  input  logic [AW-1:0]              claim_addr,
  input  logic                       flush,
  output logic [REG_NUM-1:0]         busy_vec,
  output logic [7:0]                 drop_cnt
);

  logic [DATA_W-1:0]  regs [REG_NUM];
  logic [REG_NUM-1:0] busy_nxt;
  logic               wa_ok;
  logic               wb_nz;
  logic               wb_acc;
  logic               wb_drop;
  logic               claim_ok;

  // Register 0 and addresses past the end of the array are never written,
  // claimed or read back (they read as 0).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && (32'(a) < REG_NUM);
  endfunction

  assign wa_ok    = wa_en && addr_ok(wa_addr);
  assign wb_nz    = wb_en && (wb_addr != '0);
  // Port B only lands while its load is still outstanding; anything else is
  // a stale return from before a flush or reset.
  assign wb_acc   = wb_nz && addr_ok(wb_addr) && busy_vec[wb_addr];
  assign wb_drop  = wb_nz && !wb_acc;
  assign claim_ok = claim_en && addr_ok(claim_addr);

  // Flush first, then load-return clear, then claim: a new claim always wins.
  always_comb begin
    busy_nxt = flush ? '0 : busy_vec;
    if (wb_acc) busy_nxt[wb_addr] = 1'b0;
    if (claim_ok) busy_nxt[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < REG_NUM; r++) regs[r] <= '0;
      busy_vec <= '0;
      drop_cnt <= '0;
    end else begin
      // Port A is assigned last so it wins a same-address collision.
      if (wb_acc) regs[wb_addr] <= wb_data;
      if (wa_ok) regs[wa_addr] <= wa_data;
      busy_vec <= busy_nxt;
      if (wb_drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  for (genvar i = 0; i < RD_PORTS; i++) begin : g_rd
    logic [AW-1:0]     a;
    logic [DATA_W-1:0] d;
    logic              b;

    assign a = rd_addr[i*AW +: AW];

    always_comb begin
      d = '0;
      b = 1'b0;
      if (addr_ok(a)) begin
        d = regs[a];
        b = busy_vec[a];
      end
      if (FWD != 0) begin
        // A returning load is no longer a hazard in the cycle it lands.
        if (wb_acc && (wb_addr == a)) begin
          d = wb_data;
          b = 1'b0;
        end
        if (wa_ok && (wa_addr == a)) d = wa_data;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = d;
    assign rd_busy[i]                  = b;
  end

  assign stall = |(rd_use & rd_busy);

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (FWD=1 and FWD=0)
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  rd_addr;
  logic [1:0]  rd_use;
  logic        wa_en, wb_en, claim_en, flush;
  logic [4:0]  wa_addr, wb_addr, claim_addr;
  logic [31:0] wa_data, wb_data;

  logic [63:0] rd_data1, rd_data0;
  logic [1:0]  rd_busy1, rd_busy0;
  logic        stall1, stall0;
  logic [31:0] busy_vec1, busy_vec0;
  logic [7:0]  drop_cnt1, drop_cnt0;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          m_drop;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(32), .REG_NUM(32), .RD_PORTS(2), .FWD(1)) dut1 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_use(rd_use),
    .rd_data(rd_data1), .rd_busy(rd_busy1), .stall(stall1),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush),
    .busy_vec(busy_vec1), .drop_cnt(drop_cnt1));

  regfile_mp #(.DATA_W(32), .REG_NUM(32), .RD_PORTS(2), .FWD(0)) dut0 (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_use(rd_use),
    .rd_data(rd_data0), .rd_busy(rd_busy0), .stall(stall0),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .claim_en(claim_en), .claim_addr(claim_addr), .flush(flush),
    .busy_vec(busy_vec0), .drop_cnt(drop_cnt0));

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
    m_drop = 0;
  endtask

  function automatic bit acc_now();
    return wb_en && (wb_addr != 0) && m_busy[wb_addr];
  endfunction

  function automatic logic [31:0] exp_rd(input int a, input bit fwd);
    if (fwd && wa_en && (wa_addr == a) && (a != 0)) return wa_data;
    if (fwd && acc_now() && (wb_addr == a)) return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit exp_busy(input int a, input bit fwd);
    if (a == 0) return 1'b0;
    if (fwd && acc_now() && (wb_addr == a)) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [31:0] busy_packed();
    logic [31:0] v;
    for (int r = 0; r < 32; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic check_reads();
    bit st1 = 1'b0;
    bit st0 = 1'b0;
    for (int p = 0; p < 2; p++) begin
      int a = int'(rd_addr[p*5 +: 5]);
      check_val($sformatf("rd_data_fwd1_p%0d", p), 64'(rd_data1[p*32 +: 32]), 64'(exp_rd(a, 1'b1)));
      check_val($sformatf("rd_data_fwd0_p%0d", p), 64'(rd_data0[p*32 +: 32]), 64'(exp_rd(a, 1'b0)));
      check_val($sformatf("rd_busy_fwd1_p%0d", p), 64'(rd_busy1[p]), 64'(exp_busy(a, 1'b1)));
      check_val($sformatf("rd_busy_fwd0_p%0d", p), 64'(rd_busy0[p]), 64'(exp_busy(a, 1'b0)));
      st1 |= rd_use[p] && exp_busy(a, 1'b1);
      st0 |= rd_use[p] && exp_busy(a, 1'b0);
    end
    check_val("stall_fwd1", 64'(stall1), 64'(st1));
    check_val("stall_fwd0", 64'(stall0), 64'(st0));
  endtask

  task automatic model_edge();
    bit acc = acc_now();
    if (acc) m_regs[wb_addr] = wb_data;
    if (wa_en && (wa_addr != 0)) m_regs[wa_addr] = wa_data;
    if (flush) for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
    if (acc) m_busy[wb_addr] = 1'b0;
    if (claim_en && (claim_addr != 0)) m_busy[claim_addr] = 1'b1;
    if (wb_en && (wb_addr != 0) && !acc) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
  endtask

  // Inputs are driven just after a negedge; this checks the combinational
  // outputs, clocks one edge and checks the registered state afterwards.
  task automatic cyc();
    #1;
    check_reads();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_val("busy_vec_fwd1", 64'(busy_vec1), 64'(busy_packed()));
    check_val("busy_vec_fwd0", 64'(busy_vec0), 64'(busy_packed()));
    check_val("drop_cnt_fwd1", 64'(drop_cnt1), 64'(m_drop));
    check_val("drop_cnt_fwd0", 64'(drop_cnt0), 64'(m_drop));
  endtask

  task automatic idle();
    wa_en = 0; wa_addr = '0; wa_data = '0;
    wb_en = 0; wb_addr = '0; wb_data = '0;
    claim_en = 0; claim_addr = '0; flush = 0;
    rd_addr = '0; rd_use = '0;
  endtask

  task automatic set_rd(input int a0, input int a1, input logic [1:0] use_v);
    rd_addr = {5'(a1), 5'(a0)};
    rd_use  = use_v;
  endtask

  task automatic rand_inputs();
    wa_en = 1'($urandom_range(0, 1)); wa_addr = 5'($urandom_range(0, 7)); wa_data = $urandom;
    wb_en = 1'($urandom_range(0, 1)); wb_addr = 5'($urandom_range(0, 7)); wb_data = $urandom;
    flush = ($urandom_range(0, 15) == 0);
    claim_addr = 5'($urandom_range(0, 7));
    claim_en = ($urandom_range(0, 2) == 0) &&
               (!m_busy[claim_addr] || flush || (acc_now() && (wb_addr == claim_addr)));
    set_rd($urandom_range(0, 7), $urandom_range(0, 7), 2'($urandom_range(0, 3)));
  endtask

  initial begin
    idle();
    model_reset();
    set_rd(5, 0, 2'b11);
    repeat (2) @(negedge clk);
    check_val("reset_busy_vec", 64'(busy_vec1), 64'(0));
    check_val("reset_drop_cnt", 64'(drop_cnt1), 64'(0));
    check_val("reset_rd_data", rd_data1, 64'(0));
    check_val("reset_stall", 64'(stall1), 64'(0));
    rst = 1'b1;

    // Basic write / read, and writes to x0 are ignored.
    idle(); wa_en = 1; wa_addr = 5; wa_data = 32'hDEADBEEF; cyc();
    idle(); set_rd(5, 0, 2'b00); #1;
    check_val("wa_x5_read", 64'(rd_data1[31:0]), 64'hDEADBEEF);
    check_val("x0_read", 64'(rd_data1[63:32]), 64'(0));
    cyc();
    idle(); wa_en = 1; wa_addr = 0; wa_data = 32'h1234; cyc();
    idle(); set_rd(0, 0, 2'b00); #1;
    check_val("x0_after_write", 64'(rd_data1[31:0]), 64'(0));
    cyc();

    // Bypass versus no bypass.
    idle(); wa_en = 1; wa_addr = 7; wa_data = 32'h11; set_rd(7, 0, 2'b00); #1;
    check_val("bypass_fwd1", 64'(rd_data1[31:0]), 64'h11);
    check_val("bypass_fwd0_old", 64'(rd_data0[31:0]), 64'(0));
    cyc();
    idle(); set_rd(7, 0, 2'b00); #1;
    check_val("bypass_fwd0_next", 64'(rd_data0[31:0]), 64'h11);
    cyc();

    // Load hazard and same-cycle return.
    idle(); claim_en = 1; claim_addr = 3; cyc();
    idle(); set_rd(3, 0, 2'b01); #1;
    check_val("hazard_busy", 64'(rd_busy1[0]), 64'(1));
    check_val("hazard_stall", 64'(stall1), 64'(1));
    cyc();
    idle(); wb_en = 1; wb_addr = 3; wb_data = 32'h55; set_rd(3, 0, 2'b01); #1;
    check_val("return_data", 64'(rd_data1[31:0]), 64'h55);
    check_val("return_busy", 64'(rd_busy1[0]), 64'(0));
    check_val("return_stall", 64'(stall1), 64'(0));
    cyc();
    check_val("return_busy_vec3", 64'(busy_vec1[3]), 64'(0));

    // Write collision: A data wins, B still clears busy.
    idle(); claim_en = 1; claim_addr = 9; cyc();
    idle(); wa_en = 1; wa_addr = 9; wa_data = 32'hA; wb_en = 1; wb_addr = 9; wb_data = 32'hB; cyc();
    check_val("collide_busy9", 64'(busy_vec1[9]), 64'(0));
    idle(); set_rd(9, 0, 2'b00); #1;
    check_val("collide_x9", 64'(rd_data1[31:0]), 64'hA);
    cyc();

    // Flush makes a later return stale.
    idle(); claim_en = 1; claim_addr = 4; cyc();
    idle(); flush = 1; cyc();
    idle(); wb_en = 1; wb_addr = 4; wb_data = 32'h77; cyc();
    check_val("stale_drop_cnt", 64'(drop_cnt1), 64'(1));
    idle(); set_rd(4, 0, 2'b00); #1;
    check_val("stale_x4", 64'(rd_data1[31:0]), 64'(0));
    cyc();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      cyc();
    end

    // Drop counter saturation.
    idle(); flush = 1; cyc();
    for (int n = 0; n < 300; n++) begin
      idle(); wb_en = 1; wb_addr = 4; wb_data = $urandom; cyc();
    end
    check_val("drop_saturated", 64'(drop_cnt1), 64'(255));

    // Asynchronous reset between edges, mid-load.
    idle(); claim_en = 1; claim_addr = 2; wa_en = 1; wa_addr = 6; wa_data = 32'h1; cyc();
    idle(); set_rd(6, 2, 2'b10); #1;
    check_val("pre_reset_x6", 64'(rd_data1[31:0]), 64'h1);
    check_val("pre_reset_busy2", 64'(busy_vec1[2]), 64'(1));
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_val("async_busy_vec", 64'(busy_vec1), 64'(0));
    check_val("async_drop_cnt", 64'(drop_cnt1), 64'(0));
    check_val("async_x6", 64'(rd_data1[31:0]), 64'(0));
    check_val("async_stall", 64'(stall1), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    idle(); wb_en = 1; wb_addr = 2; wb_data = 32'h99; set_rd(2, 6, 2'b11); cyc();
    check_val("post_reset_drop", 64'(drop_cnt1), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
